// File: rtl/led_fade_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : led_fade_sequencer
// Brief  : Keyframe RGB fade sequencer feeding three 8-bit PWM duty values.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module led_fade_sequencer #(
    parameter  int CLK_FREQ = 125000000,
    parameter  int TICK_HZ  = 100,
    parameter  int DEPTH    = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  logic [31:0]   WDATA,
    input  logic [AW:0]   LEN,
    input  logic          START,
    input  logic          STOP,
    output logic          BUSY,
    output logic [AW-1:0] IDX,
    output logic [7:0]    DUTY_R,
    output logic [7:0]    DUTY_G,
    output logic [7:0]    DUTY_B
);

    localparam int            c_TICK_PERIOD = CLK_FREQ / TICK_HZ;
    localparam int            c_CW          = (c_TICK_PERIOD > 1) ? $clog2(c_TICK_PERIOD) : 1;
    localparam logic [c_CW-1:0] c_TICK_LAST = c_CW'(c_TICK_PERIOD - 1);
    localparam logic [AW:0]   c_DEPTH       = (AW+1)'(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FADE = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_busy;
    logic [c_CW-1:0] r_tick_cnt;
    logic [AW-1:0]   r_idx;
    logic [AW:0]     r_len;
    logic [7:0]      r_hold_cnt;
    logic [7:0]      r_tgt_h, r_tgt_r, r_tgt_g, r_tgt_b;
    logic [7:0]      r_duty_r, r_duty_g, r_duty_b;
    logic [31:0]     r_mem [DEPTH];

    logic            w_tick;
    logic            w_start_ok;
    logic [AW:0]     w_len_clamp;
    logic [7:0]      w_nxt_r, w_nxt_g, w_nxt_b;
    logic            w_fade_done;
    logic [AW:0]     w_idx_p1;
    logic [AW-1:0]   w_idx_inc;
    logic            w_load;
    logic [AW-1:0]   w_load_idx;
    logic [31:0]     w_load_word;
    logic            w_fade_step;
    logic            w_hold_dec;

    function automatic logic [7:0] f_step(input logic [7:0] d, input logic [7:0] t);
        if (d < t)      return d + 8'd1;
        else if (d > t) return d - 8'd1;
        else            return d;
    endfunction

    assign w_tick      = (r_tick_cnt == c_TICK_LAST);
    assign w_start_ok  = START && (LEN != '0);
    assign w_len_clamp = (LEN > c_DEPTH) ? c_DEPTH : LEN;
    assign w_nxt_r     = f_step(r_duty_r, r_tgt_r);
    assign w_nxt_g     = f_step(r_duty_g, r_tgt_g);
    assign w_nxt_b     = f_step(r_duty_b, r_tgt_b);
    assign w_fade_done = (w_nxt_r == r_tgt_r) && (w_nxt_g == r_tgt_g) && (w_nxt_b == r_tgt_b);
    assign w_idx_p1    = {1'b0, r_idx} + (AW+1)'(1);
    assign w_idx_inc   = (w_idx_p1 == r_len) ? '0 : w_idx_p1[AW-1:0];
    // Same-cycle write to the entry being loaded is forwarded.
    assign w_load_word = (WE && (WADDR == w_load_idx)) ? WDATA : r_mem[w_load_idx];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_IDLE);
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_idx  = '0;
        w_fade_step = 1'b0;
        w_hold_dec  = 1'b0;
        if (STOP) begin
            w_state_nxt = c_IDLE;
        end else if (w_start_ok) begin
            w_state_nxt = c_FADE;
            w_load      = 1'b1;
        end else if (w_tick) begin
            case (r_state)
                c_FADE: begin
                    w_fade_step = 1'b1;
                    if (w_fade_done) w_state_nxt = c_HOLD;
                end
                c_HOLD: begin
                    if (r_hold_cnt == 8'd0) begin
                        w_state_nxt = c_FADE;
                        w_load      = 1'b1;
                        w_load_idx  = w_idx_inc;
                    end else begin
                        w_hold_dec  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        BUSY   = r_busy;
        IDX    = r_idx;
        DUTY_R = r_duty_r;
        DUTY_G = r_duty_g;
        DUTY_B = r_duty_b;
    end

    always_ff @(posedge CLK) begin
        if (WE) r_mem[WADDR] <= WDATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tick_cnt <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_hold_cnt <= 8'd0;
            r_tgt_h    <= 8'd0;
            r_tgt_r    <= 8'd0;
            r_tgt_g    <= 8'd0;
            r_tgt_b    <= 8'd0;
            r_duty_r   <= 8'd0;
            r_duty_g   <= 8'd0;
            r_duty_b   <= 8'd0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_CW'(1);
            if (w_start_ok) r_len <= w_len_clamp;
            if (w_load) begin
                r_idx   <= w_load_idx;
                r_tgt_h <= w_load_word[31:24];
                r_tgt_r <= w_load_word[23:16];
                r_tgt_g <= w_load_word[15:8];
                r_tgt_b <= w_load_word[7:0];
            end
            if (w_fade_step) begin
                r_duty_r <= w_nxt_r;
                r_duty_g <= w_nxt_g;
                r_duty_b <= w_nxt_b;
                if (w_fade_done) r_hold_cnt <= r_tgt_h;
            end
            if (w_hold_dec) r_hold_cnt <= r_hold_cnt - 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_fade_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_led_fade_sequencer
// Brief  : Directed table-driven bench for led_fade_sequencer (tick = 10 clocks).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_fade_sequencer;

    logic        CLK = 1'b0;
    logic        RST, WE, START, STOP;
    logic [2:0]  WADDR;
    logic [31:0] WDATA;
    logic [3:0]  LEN;
    logic        BUSY;
    logic [2:0]  IDX;
    logic [7:0]  DUTY_R, DUTY_G, DUTY_B;

    int total = 0;
    int bad   = 0;

    led_fade_sequencer #(.CLK_FREQ(1000), .TICK_HZ(100), .DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .LEN(LEN),
        .START(START), .STOP(STOP), .BUSY(BUSY), .IDX(IDX),
        .DUTY_R(DUTY_R), .DUTY_G(DUTY_G), .DUTY_B(DUTY_B)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  len;
        logic        start;
        logic        stop;
        int          ticks;
        logic        busy;
        logic [2:0]  idx;
        logic [7:0]  r, g, b;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [3:0] len, input logic st, input logic sp, input int ticks,
                       input logic busy, input logic [2:0] idx, input logic [7:0] r, g, b);
        vec_t v;
        v.rst = rst; v.we = we; v.waddr = wa; v.wdata = wd; v.len = len; v.start = st; v.stop = sp;
        v.ticks = ticks; v.busy = busy; v.idx = idx; v.r = r; v.g = g; v.b = b;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Advance until one tick edge has been processed.
    task automatic next_tick();
        int n = 0;
        while (dut.w_tick !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) chk("tick_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic chk_out(input string tag, input logic busy, input logic [2:0] idx,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        chk({tag, "_busy"}, {31'd0, BUSY}, {31'd0, busy});
        chk({tag, "_idx"},  {29'd0, IDX},  {29'd0, idx});
        chk({tag, "_duty"}, {8'd0, DUTY_R, DUTY_G, DUTY_B}, {8'd0, r, g, b});
    endtask

    initial begin
        RST = 1'b1; WE = 1'b0; START = 1'b0; STOP = 1'b0;
        WADDR = '0; WDATA = '0; LEN = '0;
        repeat (3) step();
        RST = 1'b0;
        chk_out("reset", 1'b0, 3'd0, 8'd0, 8'd0, 8'd0);

        // Tick pulse every 10 clocks, one clock wide
        for (int k = 1; k <= 30; k++) begin
            step();
            chk($sformatf("tick_k%0d", k), {31'd0, dut.w_tick}, {31'd0, (k % 10) == 9});
        end

        // rst we  wa  wdata        len st sp ticks busy idx  r      g      b
        // Basic fade, hold length, deferred edit
        add(0, 1, 0, 32'h02030002, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        1, 1, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h01, 8'h00, 8'h01);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h02, 8'h00, 8'h02);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h03, 8'h00, 8'h02);
        add(0, 1, 0, 32'h00050002, 0, 0, 0, 0,  1, 0, 8'h03, 8'h00, 8'h02);
        add(0, 0, 0, 32'h0,        0, 0, 0, 2,  1, 0, 8'h03, 8'h00, 8'h02);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h03, 8'h00, 8'h02);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h04, 8'h00, 8'h02);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h05, 8'h00, 8'h02);
        add(0, 0, 0, 32'h0,        0, 0, 0, 2,  1, 0, 8'h05, 8'h00, 8'h02);
        // Stop freezes; wrap and down-fade with LEN=2
        add(0, 0, 0, 32'h0,        0, 0, 1, 0,  0, 0, 8'h05, 8'h00, 8'h02);
        add(0, 0, 0, 32'h0,        0, 0, 0, 5,  0, 0, 8'h05, 8'h00, 8'h02);
        add(1, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 1, 0, 32'h00100000, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 1, 1, 32'h00000000, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        2, 1, 0, 15, 1, 0, 8'h0f, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h10, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'h10, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'h0f, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        0, 0, 0, 15, 1, 1, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h01, 8'h00, 8'h00);
        // LEN=0 start ignored
        add(0, 0, 0, 32'h0,        0, 0, 1, 0,  0, 0, 8'h01, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        0, 1, 0, 3,  0, 0, 8'h01, 8'h00, 8'h00);
        // START+STOP collision while busy
        add(1, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 1, 0, 32'h00804020, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 32'h0,        1, 1, 0, 5,  1, 0, 8'h05, 8'h05, 8'h05);
        add(0, 0, 0, 32'h0,        1, 1, 1, 0,  0, 0, 8'h05, 8'h05, 8'h05);
        add(0, 0, 0, 32'h0,        0, 0, 0, 50, 0, 0, 8'h05, 8'h05, 8'h05);
        // Restart from the current colour
        add(0, 1, 0, 32'h00101010, 0, 0, 0, 0,  0, 0, 8'h05, 8'h05, 8'h05);
        add(0, 1, 1, 32'h00000000, 0, 0, 0, 0,  0, 0, 8'h05, 8'h05, 8'h05);
        add(0, 0, 0, 32'h0,        2, 1, 0, 3,  1, 0, 8'h08, 8'h08, 8'h08);
        add(0, 0, 0, 32'h0,        2, 1, 0, 0,  1, 0, 8'h08, 8'h08, 8'h08);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h09, 8'h09, 8'h09);
        add(0, 0, 0, 32'h0,        0, 0, 0, 7,  1, 0, 8'h10, 8'h10, 8'h10);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'h10, 8'h10, 8'h10);
        add(0, 0, 0, 32'h0,        0, 0, 0, 2,  1, 1, 8'h0e, 8'h0e, 8'h0e);
        add(0, 0, 0, 32'h0,        2, 1, 0, 0,  1, 0, 8'h0e, 8'h0e, 8'h0e);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h0f, 8'h0f, 8'h0f);
        add(0, 0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h10, 8'h10, 8'h10);

        for (int i = 0; i < vq.size(); i++) begin
            RST = vq[i].rst; WE = vq[i].we; WADDR = vq[i].waddr; WDATA = vq[i].wdata;
            LEN = vq[i].len; START = vq[i].start; STOP = vq[i].stop;
            step();
            RST = 1'b0; WE = 1'b0; START = 1'b0; STOP = 1'b0;
            for (int t = 0; t < vq[i].ticks; t++) next_tick();
            chk_out($sformatf("v%0d", i), vq[i].busy, vq[i].idx, vq[i].r, vq[i].g, vq[i].b);
        end

        // Write bypass: entry 1 rewritten on the very edge it is loaded
        begin
            int n = 0;
            while (dut.w_tick !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            if (n >= 30) chk("bypass_timeout", 32'd1, 32'd0);
            WE = 1'b1; WADDR = 3'd1; WDATA = 32'h00301010;
            step();
            WE = 1'b0;
            chk_out("bypass_load", 1'b1, 3'd1, 8'h10, 8'h10, 8'h10);
            next_tick();
            chk_out("bypass_fade", 1'b1, 3'd1, 8'h11, 8'h10, 8'h10);
        end

        // LEN=15 clamps to 8 entries; IDX cycles 0..7 then wraps
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int e = 0; e < 8; e++) begin
            WE = 1'b1; WADDR = 3'(e); WDATA = 32'h0;
            step();
        end
        WE = 1'b0;
        LEN = 4'd15; START = 1'b1;
        step();
        START = 1'b0; LEN = 4'd0;
        chk_out("len15_start", 1'b1, 3'd0, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            next_tick();
            next_tick();
            chk($sformatf("len15_idx%0d", k), {29'd0, IDX}, 32'(k % 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
